float_to_fixed_stream: RTL
==========================

// Module: float_to_fixed_stream
// PURPOSE
// - Downstream consumer of the pipelined float multiplier product bus.
// - Converts IEEE-style floats to signed two's-complement fixed point, with saturation.
// - 2-stage pipeline with valid/ready handshake. Backpressure from the fixed-point sink
//   stalls the pipeline without losing or reordering data.
// PARAMETERS
// - MANTISSA_SIZE   23  stored mantissa bits (hidden bit implicit)
// - EXPONENT_SIZE    8  exponent bits; bias = 2**(EXPONENT_SIZE-1)-1
// - INT_SIZE        32  total output width, signed
// - FRACTION_BITS   16  output fraction bits (output LSB = 2**-FRACTION_BITS)
// PORTS
// - clk        in   1                  clock, all logic on posedge
// - reset      in   1                  synchronous, active-high
// - floatIn    in   1+EXP+MANT         {sign, exponent, mantissa}
// - inValid    in   1                  floatIn valid
// - inReady    out  1                  block accepts floatIn this cycle
// - fixedOut   out  INT_SIZE           converted value
// - saturated  out  1                  fixedOut was clamped (qualifies with outValid)
// - outValid   out  1                  fixedOut/saturated valid
// - outReady   in   1                  sink accepts fixedOut this cycle
// BEHAVIOUR
// - Reset: s1Valid=0, outValid=0, fixedOut=0, saturated=0.
//   Reset mid-stream discards all in-flight data; inReady=1 on the cycle after reset drops.
// - Handshake:
//   - Input transfer when inValid&&inReady; output transfer when outValid&&outReady.
//   - advance = !outValid || outReady.
//   - inReady = !s1Valid || advance (combinational, no registered ready).
//   - Stage 2 loads from stage 1 when advance; outValid <= s1Valid at that edge.
//   - Stage 1 loads when inReady; s1Valid <= inValid.
//   - Stalled with outValid=1: fixedOut/saturated held stable until outReady.
//   - No bubbles inserted; max capacity 2 items; strict FIFO order.
//   - Latency: accepted input appears on outValid 2 cycles later when unstalled.
//     Sustained throughput 1/cycle with outReady=1.
// - Stage 1 (unpack):
//   - sign, exp, mant = {exp!=0, mantissa}.
//   - Signed shift amount sh = exp - bias + FRACTION_BITS - MANTISSA_SIZE,
//     width EXPONENT_SIZE+2 (no wrap).
//   - Class: ZERO if exp==0 (subnormals flushed to 0); SAT if exp==all-ones (inf/NaN);
//     SAT if exp-bias+FRACTION_BITS >= INT_SIZE-1; NORMAL otherwise.
// - Stage 2 (convert):
//   - NORMAL magnitude = sh>=0 ? mant<<sh : mant>>(-sh), truncated (toward zero);
//     shifts >= width yield 0.
//   - Result = sign ? -magnitude : magnitude; -0 outputs 0.
//   - SAT: positive -> 2**(INT_SIZE-1)-1, negative -> -2**(INT_SIZE-1), saturated=1.
//   - Exception: negative, exp-bias+FRACTION_BITS == INT_SIZE-1, mantissa==0
//     is exactly -2**(INT_SIZE-1); output min with saturated=0.
//   - ZERO: fixedOut=0, saturated=0. NaN saturates by its sign bit.
// - Internal widths sized so no intermediate truncation precedes the saturation test.
// TESTING (defaults; outReady=1 unless stated)
// - T1: 0x3FC00000 (1.5) -> fixedOut 0x00018000, sat 0, exactly 2 cycles after accept.
// - T2: 0xC0100000 (-2.25) -> 0xFFFDC000 sat 0. 0x35800000 (2^-20) -> 0 sat 0.
//   0x00000001 -> 0 sat 0.
// - T3: 0x501502F9 (1e10) -> 0x7FFFFFFF sat 1. 0xFF800000 (-inf) -> 0x80000000 sat 1.
//   0xC7000000 (-32768.0) -> 0x80000000 sat 0. 0x47000000 (+32768.0) -> 0x7FFFFFFF sat 1.
// - T4: inValid=1 every cycle, 8 values, outReady toggling 1/0 pseudo-randomly.
//   Expect: all 8 outputs in order, none dropped or duplicated; inReady low only with
//   both stages full and outReady=0; fixedOut stable during stalls.
// - T5: outReady=0 with 2 items in flight, assert reset 1 cycle.
//   Expect: outValid=0 and inReady=1 next cycle; the stale items never appear.
// - T6: back-to-back 1000 random floats, outReady=1.
//   Expect: one output per cycle, bit-exact vs software truncate+saturate model.

Source files
------------

// File: rtl/float_to_fixed_stream.sv
// Streaming float -> signed fixed-point converter with saturation.
// Two-stage valid/ready pipeline: stage 1 unpacks and classifies, stage 2 shifts and clamps.
module float_to_fixed_stream #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32,
    parameter int FRACTION_BITS = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] floatIn,
    input  logic                                 inValid,
    output logic                                 inReady,
    output logic [INT_SIZE-1:0]                  fixedOut,
    output logic                                 saturated,
    output logic                                 outValid,
    input  logic                                 outReady
);

    localparam int FLOAT_W = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    localparam int BIAS    = 2 ** (EXPONENT_SIZE - 1) - 1;
    localparam int SH_W    = EXPONENT_SIZE + 2;
    localparam int MAG_W   = INT_SIZE + MANTISSA_SIZE + 1;

    localparam logic [INT_SIZE-1:0] FIXED_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0] FIXED_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_SAT,
        CLS_MIN
    } class_t;

    logic                     advance;
    logic                     in_sign;
    logic [EXPONENT_SIZE-1:0] in_exp;
    logic [MANTISSA_SIZE-1:0] in_frac;
    int                       in_scale;
    logic signed [SH_W-1:0]   in_sh;
    class_t                   in_class;

    logic                     s1_valid;
    logic                     s1_sign;
    logic [MANTISSA_SIZE:0]   s1_mant;
    logic signed [SH_W-1:0]   s1_sh;
    class_t                   s1_class;

    logic [MAG_W-1:0]         mant_wide;
    logic [MAG_W-1:0]         magnitude;
    logic [SH_W-1:0]          sh_abs;
    logic                     mag_overflow;
    logic [INT_SIZE-1:0]      conv_value;
    logic                     conv_sat;

    assign advance = !outValid || outReady;
    assign inReady = !s1_valid || advance;

    assign in_sign = floatIn[FLOAT_W-1];
    assign in_exp  = floatIn[FLOAT_W-2:MANTISSA_SIZE];
    assign in_frac = floatIn[MANTISSA_SIZE-1:0];

    // in_scale is the binary weight of the hidden bit in output-LSB units
    always_comb begin
        in_scale = 32'(in_exp) - BIAS + FRACTION_BITS;
        in_sh    = SH_W'(in_scale - MANTISSA_SIZE);
        if (in_exp == '0)
            in_class = CLS_ZERO;
        else if (in_exp == '1)
            in_class = CLS_SAT;
        else if (in_scale >= INT_SIZE - 1) begin
            if (in_sign && in_scale == INT_SIZE - 1 && in_frac == '0)
                in_class = CLS_MIN;
            else
                in_class = CLS_SAT;
        end else
            in_class = CLS_NORMAL;
    end

    // Wide magnitude keeps every shifted bit so overflow can still be detected
    always_comb begin
        mant_wide    = MAG_W'(s1_mant);
        sh_abs       = s1_sh[SH_W-1] ? $unsigned(-s1_sh) : $unsigned(s1_sh);
        magnitude    = s1_sh[SH_W-1] ? (mant_wide >> sh_abs) : (mant_wide << sh_abs);
        mag_overflow = |magnitude[MAG_W-1:INT_SIZE-1];
        conv_value   = '0;
        conv_sat     = 1'b0;
        unique case (s1_class)
            CLS_ZERO: begin
                conv_value = '0;
                conv_sat   = 1'b0;
            end
            CLS_NORMAL: begin
                if (mag_overflow) begin
                    conv_value = s1_sign ? FIXED_MIN : FIXED_MAX;
                    conv_sat   = 1'b1;
                end else begin
                    conv_value = s1_sign ? -magnitude[INT_SIZE-1:0] : magnitude[INT_SIZE-1:0];
                    conv_sat   = 1'b0;
                end
            end
            CLS_SAT: begin
                conv_value = s1_sign ? FIXED_MIN : FIXED_MAX;
                conv_sat   = 1'b1;
            end
            CLS_MIN: begin
                conv_value = FIXED_MIN;
                conv_sat   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            outValid  <= 1'b0;
            fixedOut  <= '0;
            saturated <= 1'b0;
        end else begin
            if (inReady) begin
                s1_valid <= inValid;
                s1_sign  <= in_sign;
                s1_mant  <= {in_exp != '0, in_frac};
                s1_sh    <= in_sh;
                s1_class <= in_class;
            end
            if (advance) begin
                outValid  <= s1_valid;
                fixedOut  <= conv_value;
                saturated <= conv_sat;
            end
        end
    end

endmodule
